regfile_scoreboard: RTL

//  Parametrised integer register file for the pipelined and multicycle RV cores.
//  - Two synchronous write ports: port 0 = ALU/early writeback, port 1 = late writeback (load/mul/div).
//  - Two bypassed architectural read ports plus a registered debug/VGA read port.
//  - Per-register busy scoreboard with a live busy count, so the hazard unit can stall on

---
 rtl/regfile_scoreboard.sv | 93 +++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// Integer register file: two write ports, two bypassed read ports, a registered debug read port,
// and a per-register busy scoreboard with a live busy count for long-latency results.
module regfile_scoreboard #(
   parameter int              XLEN     = 32,
   parameter int              NREG     = 32,
   parameter int              SP_INDEX = 2,
   parameter logic [XLEN-1:0] SP_RESET = 32'h1001_03FC,
   parameter bit              BYPASS   = 1'b1,
   localparam int             AW       = $clog2(NREG)
) (
   input  logic            iCLK,
   input  logic            iRST,
   input  logic [AW-1:0]   iRs1,
   input  logic [AW-1:0]   iRs2,
   output logic [XLEN-1:0] oRd1,
   output logic [XLEN-1:0] oRd2,
   output logic            oRs1Busy,
   output logic            oRs2Busy,
   input  logic            iWe0,
   input  logic [AW-1:0]   iWa0,
   input  logic [XLEN-1:0] iWd0,
   input  logic            iWe1,
   input  logic [AW-1:0]   iWa1,
   input  logic [XLEN-1:0] iWd1,
   input  logic            iReserve,
   input  logic [AW-1:0]   iResAddr,
   output logic            oResErr,
   output logic [AW:0]     oBusyCount,
   input  logic [AW-1:0]   iDbgSel,
   output logic [XLEN-1:0] oDbgData
);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy;
   logic [AW:0]     busy_count;
   logic            res_err;
   logic [XLEN-1:0] dbg_data;

   logic we0_ok, we1_ok;
   logic res_clr_same, res_ok, res_rej, set_new, clr_eff;

   assign we0_ok = iWe0 && (iWa0 != '0);
   assign we1_ok = iWe1 && (iWa1 != '0);

   // A reserve landing on a register that retires this same cycle is accepted, not an error.
   assign res_clr_same = iWe1 && (iWa1 == iResAddr);
   assign res_ok  = iReserve && (iResAddr != '0) && (!busy[iResAddr] || res_clr_same);
   assign res_rej = iReserve && (iResAddr != '0) && busy[iResAddr] && !res_clr_same;
   assign set_new = res_ok && !busy[iResAddr];
   assign clr_eff = we1_ok && busy[iWa1] && !(res_ok && (iResAddr == iWa1));

   always_comb begin
      oRd1 = regs[iRs1];
      if (BYPASS && we0_ok && (iWa0 == iRs1)) oRd1 = iWd0;
      if (BYPASS && we1_ok && (iWa1 == iRs1)) oRd1 = iWd1;
      if (iRs1 == '0) oRd1 = '0;
   end

   always_comb begin
      oRd2 = regs[iRs2];
      if (BYPASS && we0_ok && (iWa0 == iRs2)) oRd2 = iWd0;
      if (BYPASS && we1_ok && (iWa1 == iRs2)) oRd2 = iWd1;
      if (iRs2 == '0) oRd2 = '0;
   end

   assign oRs1Busy = busy[iRs1] && !(BYPASS && iWe1 && (iWa1 == iRs1));
   assign oRs2Busy = busy[iRs2] && !(BYPASS && iWe1 && (iWa1 == iRs2));

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         for (int i = 0; i < NREG; i++)
            regs[i] <= (i == SP_INDEX) ? SP_RESET : '0;
         busy       <= '0;
         busy_count <= '0;
         res_err    <= 1'b0;
         dbg_data   <= '0;
      end else begin
         dbg_data <= regs[iDbgSel];
         // Port 1 is assigned last so it wins an address collision.
         if (we0_ok) regs[iWa0] <= iWd0;
         if (we1_ok) regs[iWa1] <= iWd1;
         if (we1_ok && !(res_ok && (iResAddr == iWa1))) busy[iWa1] <= 1'b0;
         if (res_ok) busy[iResAddr] <= 1'b1;
         busy_count <= busy_count + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_eff};
         res_err    <= res_rej;
      end
   end

   assign oResErr    = res_err;
   assign oBusyCount = busy_count;
   assign oDbgData   = dbg_data;

endmodule
